// File: rtl/downsizer.sv
// Wide-to-narrow width converter: accepts one wide word and replays it as up to
// RATIO narrow beats, least-significant slice first, with valid/ready on both sides.
module downsizer #(
  parameter int INP_DATA_WIDTH = 128,
  parameter int OUT_DATA_WIDTH = 32,
  parameter int RATIO          = INP_DATA_WIDTH / OUT_DATA_WIDTH,
  parameter int CNT_WIDTH      = $clog2(RATIO) + 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [INP_DATA_WIDTH*8-1:0] in_data,
  input  logic [CNT_WIDTH-1:0]        in_beats,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [OUT_DATA_WIDTH*8-1:0] out_data,
  output logic                        out_last,
  output logic [CNT_WIDTH-2:0]        out_idx
);

  localparam int OUT_W = OUT_DATA_WIDTH * 8;

  typedef enum logic {
    IDLE,
    SEND
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_WIDTH-1:0]        beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]        beats_q, beats_d;
  logic [RATIO-1:0][OUT_W-1:0] hold_q, hold_d;

  logic                        accept;
  logic [CNT_WIDTH-1:0]        beats_clamped;

  // A zero or oversized beat count means "send the whole word".
  assign beats_clamped = ((in_beats == '0) || (in_beats > CNT_WIDTH'(RATIO)))
                         ? CNT_WIDTH'(RATIO) : in_beats;

  assign out_valid = (state_q == SEND);
  assign out_idx   = beat_cnt_q[CNT_WIDTH-2:0];
  assign out_last  = out_valid && (beat_cnt_q == beats_q - CNT_WIDTH'(1));
  assign out_data  = out_valid ? hold_q[out_idx] : '0;

  // Ready again in the same cycle the last beat leaves, so words stream with
  // no bubble; held low while reset is asserted.
  assign in_ready  = !rstn && ((state_q == IDLE) || (out_valid && out_ready && out_last));
  assign accept    = in_valid && in_ready;

  // NOTE: every _d gets its hold value first so no path through this block
  // leaves a variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    beats_d    = beats_q;
    hold_d     = hold_q;

    case (state_q)
      IDLE: ;
      SEND: begin
        if (out_ready) begin
          if (out_last) state_d = IDLE;
          else          beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A new word overrides the return to IDLE when it arrives on the last beat.
    if (accept) begin
      state_d    = SEND;
      beat_cnt_d = '0;
      beats_d    = beats_clamped;
      hold_d     = in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering. The wide hold register is
  // reset as well so out_data reads zero straight out of reset.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      beats_q    <= '0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      beats_q    <= beats_d;
      hold_q     <= hold_d;
    end
  end

endmodule

// File: tb/tb_downsizer.sv
// Directed and scoreboarded checks for downsizer with 128-byte words split into
// 32-byte beats (RATIO = 4).
module tb_downsizer;

  localparam int IW    = 128;
  localparam int OW    = 32;
  localparam int RATIO = 4;
  localparam int CW    = 3;
  localparam int WB    = IW * 8;
  localparam int OB    = OW * 8;

  logic          clk;
  logic          rstn;
  logic          in_valid;
  logic          in_ready;
  logic [WB-1:0] in_data;
  logic [CW-1:0] in_beats;
  logic          out_valid;
  logic          out_ready;
  logic [OB-1:0] out_data;
  logic          out_last;
  logic [CW-2:0] out_idx;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [OB-1:0] data;
    logic [CW-2:0] idx;
    logic          last;
  } beat_t;

  beat_t sb[$];

  downsizer #(
    .INP_DATA_WIDTH(IW),
    .OUT_DATA_WIDTH(OW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_beats (in_beats),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_idx  (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OB-1:0] obs, input logic [OB-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word whose slice k is the 32-bit value base+k repeated across the slice.
  function automatic logic [WB-1:0] mk_word(input logic [31:0] base);
    logic [WB-1:0] w;
    for (int k = 0; k < RATIO; k++) w[k*OB +: OB] = {8{base + 32'(k)}};
    return w;
  endfunction

  function automatic logic [OB-1:0] slice(input logic [WB-1:0] w, input int k);
    return w[k*OB +: OB];
  endfunction

  function automatic logic [WB-1:0] rand_word();
    logic [WB-1:0] w;
    for (int i = 0; i < WB / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  task automatic chk_beat(input string t, input logic [WB-1:0] w, input int k,
                          input logic last, input logic rdy);
    check({t, ".valid"}, OB'(out_valid), OB'(1'b1));
    check({t, ".data"},  out_data,       slice(w, k));
    check({t, ".idx"},   OB'(out_idx),   OB'(k));
    check({t, ".last"},  OB'(out_last),  OB'(last));
    check({t, ".ready"}, OB'(in_ready),  OB'(rdy));
  endtask

  task automatic chk_idle(input string t);
    check({t, ".idle_valid"}, OB'(out_valid), OB'(1'b0));
    check({t, ".idle_ready"}, OB'(in_ready),  OB'(1'b1));
    check({t, ".idle_last"},  OB'(out_last),  OB'(1'b0));
  endtask

  // Present one word from IDLE with out_ready held high and check every beat.
  task automatic send_word(input string t, input logic [WB-1:0] w,
                           input logic [CW-1:0] beats, input int exp_n);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = w;
    in_beats  = beats;
    out_ready = 1'b1;
    #1;
    check({t, ".acc_ready"}, OB'(in_ready),  OB'(1'b1));
    check({t, ".acc_valid"}, OB'(out_valid), OB'(1'b0));
    for (int k = 0; k < exp_n; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk_beat(t, w, k, k == exp_n - 1, k == exp_n - 1);
    end
    @(negedge clk);
    #1;
    chk_idle(t);
  endtask

  initial begin
    logic [WB-1:0] w0, w1, wd, wr;
    logic          pv, pr;
    logic [OB-1:0] pd;
    int            sent, cyc, nb;

    rstn      = 1'b1;
    in_valid  = 1'b1;
    in_data   = mk_word(32'h0000_00EE);
    in_beats  = 3'd4;
    out_ready = 1'b1;

    // Reset state, with a word offered that must not be taken.
    repeat (2) @(negedge clk);
    #1;
    check("rst.valid", OB'(out_valid), OB'(1'b0));
    check("rst.data",  out_data,       '0);
    check("rst.last",  OB'(out_last),  OB'(1'b0));
    check("rst.idx",   OB'(out_idx),   OB'(0));
    check("rst.ready", OB'(in_ready),  OB'(1'b0));
    @(negedge clk);
    in_valid = 1'b0;
    rstn     = 1'b0;
    #1;
    chk_idle("rst_rel");

    // Full word, slices A0..A3.
    send_word("full", mk_word(32'h0000_00A0), 3'd4, 4);

    // Back-to-back words; W1 is presented early and must be ignored until ready.
    w0 = mk_word(32'h0000_00B0);
    w1 = mk_word(32'h0000_00C0);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = w0;
    in_beats  = 3'd4;
    out_ready = 1'b1;
    #1;
    check("b2b.acc_ready", OB'(in_ready), OB'(1'b1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_data = w1;
      #1;
      chk_beat("b2b_w0", w0, k, k == 3, k == 3);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk_beat("b2b_w1", w1, k, k == 3, k == 3);
    end
    @(negedge clk);
    #1;
    chk_idle("b2b");

    // Backpressure for 3 cycles on idx 1 while junk is offered on the input.
    wd = mk_word(32'h0000_00D0);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = wd;
    in_beats  = 3'd4;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk_beat("bp0", wd, 0, 1'b0, 1'b0);
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = mk_word(32'h0000_0055);
      #1;
      chk_beat("bp_stall", wd, 1, 1'b0, 1'b0);
    end
    for (int k = 1; k < 4; k++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      #1;
      chk_beat("bp_resume", wd, k, k == 3, k == 3);
    end
    @(negedge clk);
    #1;
    chk_idle("bp");

    // Partial and clamped word lengths.
    send_word("part2",  mk_word(32'h0000_00E0), 3'd2, 2);
    send_word("part1",  mk_word(32'h0000_00E8), 3'd1, 1);
    send_word("beats0", mk_word(32'h0000_00F0), 3'd0, 4);
    send_word("beats7", mk_word(32'h0000_00F8), 3'd7, 4);

    // Reset asserted after idx 1 has been taken.
    wr = mk_word(32'h0000_0090);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = wr;
    in_beats  = 3'd4;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk_beat("mid", wr, k, 1'b0, 1'b0);
    end
    rstn = 1'b1;
    #1;
    check("mid_rst.valid", OB'(out_valid), OB'(1'b0));
    check("mid_rst.data",  out_data,       '0);
    check("mid_rst.idx",   OB'(out_idx),   OB'(0));
    check("mid_rst.ready", OB'(in_ready),  OB'(1'b0));
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk_idle("mid_rel");
    send_word("after_rst", mk_word(32'h0000_0070), 3'd4, 4);

    // Random valid/ready against a beat scoreboard.
    sent = 0;
    cyc  = 0;
    pv   = 1'b0;
    pr   = 1'b0;
    pd   = '0;
    while ((sent < 300 || sb.size() > 0) && cyc < 20000) begin
      @(negedge clk);
      in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
      in_data   = rand_word();
      in_beats  = CW'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (pv && !pr) begin
        check("rnd.hold_valid", OB'(out_valid), OB'(1'b1));
        check("rnd.hold_data",  out_data,       pd);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("rnd.extra_beat", OB'(out_valid), OB'(1'b0));
        end else begin
          beat_t b;
          b = sb.pop_front();
          check("rnd.data", out_data,      b.data);
          check("rnd.idx",  OB'(out_idx),  OB'(b.idx));
          check("rnd.last", OB'(out_last), OB'(b.last));
        end
      end
      if (in_valid && in_ready) begin
        nb = (in_beats == 0 || in_beats > 3'd4) ? 4 : int'(in_beats);
        for (int k = 0; k < nb; k++) begin
          beat_t b;
          b.data = slice(in_data, k);
          b.idx  = (CW-1)'(k);
          b.last = (k == nb - 1);
          sb.push_back(b);
        end
        sent++;
      end
      pv = out_valid;
      pr = out_ready;
      pd = out_data;
      cyc++;
    end
    check("rnd.words_sent",  OB'(sent),      OB'(300));
    check("rnd.sb_drained",  OB'(sb.size()), OB'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
